// File: rtl/branch_fetch_ctrl_if.sv
// Fetch/redirect bundle between the pipeline (master) and the fetch controller (slave).
// Signal names keep the controller's _i/_o perspective so both sides read the same.
interface branch_fetch_ctrl_if;
    logic [31:0] instr_i;
    logic        stall_i;
    logic        halt_i;
    logic        ex_valid_i;
    logic        ex_branch_i;
    logic [1:0]  ex_branch_type_i;
    logic        ex_jump_i;
    logic        ex_zero_i;
    logic        ex_sign_i;
    logic [31:0] ex_pc_plus4_i;
    logic [31:0] ex_imm_i;
    logic [25:0] ex_jtarget_i;

    logic [31:0] pc_o;
    logic [31:0] instr_o;
    logic [31:0] pc_plus4_o;
    logic        valid_o;
    logic        flush_o;
    logic [15:0] redirect_cnt_o;

    modport slave (
        input  instr_i, stall_i, halt_i,
        input  ex_valid_i, ex_branch_i, ex_branch_type_i, ex_jump_i,
        input  ex_zero_i, ex_sign_i, ex_pc_plus4_i, ex_imm_i, ex_jtarget_i,
        output pc_o, instr_o, pc_plus4_o, valid_o, flush_o, redirect_cnt_o
    );

    modport master (
        output instr_i, stall_i, halt_i,
        output ex_valid_i, ex_branch_i, ex_branch_type_i, ex_jump_i,
        output ex_zero_i, ex_sign_i, ex_pc_plus4_i, ex_imm_i, ex_jtarget_i,
        input  pc_o, instr_o, pc_plus4_o, valid_o, flush_o, redirect_cnt_o
    );
endinterface

// File: rtl/branch_fetch_ctrl.sv
// Instruction fetch controller: PC sequencing, IF/ID register, EX-stage branch/jump
// redirect with a one-cycle flush bubble, stall/halt handling and a redirect counter.
module branch_fetch_ctrl (
    input  logic               clk_i,
    input  logic               rst_i,
    branch_fetch_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic        valid_q, valid_d;
    logic        flush_q, flush_d;
    logic [15:0] redirect_cnt_q, redirect_cnt_d;

    logic        br_cond;
    logic        br_taken;
    logic        jmp_taken;
    logic        redirect;
    logic [31:0] br_target;
    logic [31:0] jmp_target;
    logic [31:0] redirect_target;
    logic [31:0] pc_next_seq;

    // Branch condition decode and redirect target selection.
    always_comb begin
        unique case (bus.ex_branch_type_i)
            2'b00:   br_cond = bus.ex_zero_i;
            2'b01:   br_cond = bus.ex_zero_i | bus.ex_sign_i;
            2'b10:   br_cond = bus.ex_sign_i;
            default: br_cond = ~bus.ex_zero_i;
        endcase
    end

    assign br_taken        = bus.ex_valid_i & bus.ex_branch_i & br_cond;
    assign jmp_taken       = bus.ex_valid_i & bus.ex_jump_i;
    assign redirect        = br_taken | jmp_taken;
    assign br_target       = bus.ex_pc_plus4_i + {bus.ex_imm_i[29:0], 2'b00};
    assign jmp_target      = {bus.ex_pc_plus4_i[31:28], bus.ex_jtarget_i, 2'b00};
    assign redirect_target = jmp_taken ? jmp_target : br_target;
    assign pc_next_seq     = pc_q + 32'd4;

    // Next-state and datapath updates for every state.
    always_comb begin
        // NOTE: every variable gets a hold/default value first, so no path through
        // the case statement can leave one unassigned and infer a latch.
        state_d        = state_q;
        pc_d           = pc_q;
        instr_d        = instr_q;
        pc_plus4_d     = pc_plus4_q;
        valid_d        = valid_q;
        flush_d        = 1'b0;
        redirect_cnt_d = redirect_cnt_q;

        unique case (state_q)
            ST_BOOT: begin
                // Spend one cycle covering the instruction-memory read latency of address 0.
                pc_d    = 32'd0;
                valid_d = 1'b0;
                state_d = ST_FETCH;
            end

            ST_FETCH: begin
                if (redirect) begin
                    pc_d    = redirect_target;
                    instr_d = 32'd0;
                    valid_d = 1'b0;
                    flush_d = 1'b1;
                    state_d = ST_FLUSH;
                    if (redirect_cnt_q != 16'hFFFF) begin
                        redirect_cnt_d = redirect_cnt_q + 16'd1;
                    end
                end else if (bus.halt_i) begin
                    instr_d = 32'd0;
                    valid_d = 1'b0;
                    state_d = ST_HALT;
                end else if (!bus.stall_i) begin
                    instr_d    = bus.instr_i;
                    pc_plus4_d = pc_next_seq;
                    valid_d    = 1'b1;
                    pc_d       = pc_next_seq;
                end
            end

            ST_FLUSH: begin
                // Target is being read this cycle; EX still holds the squashed path.
                instr_d = 32'd0;
                valid_d = 1'b0;
                state_d = ST_FETCH;
            end

            ST_HALT: begin
                instr_d = 32'd0;
                valid_d = 1'b0;
            end

            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples
        // the pre-edge values computed above, independent of statement order.
        if (rst_i) begin
            state_q        <= ST_BOOT;
            pc_q           <= 32'd0;
            instr_q        <= 32'd0;
            pc_plus4_q     <= 32'd0;
            valid_q        <= 1'b0;
            flush_q        <= 1'b0;
            redirect_cnt_q <= 16'd0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            instr_q        <= instr_d;
            pc_plus4_q     <= pc_plus4_d;
            valid_q        <= valid_d;
            flush_q        <= flush_d;
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    assign bus.pc_o           = pc_q;
    assign bus.instr_o        = instr_q;
    assign bus.pc_plus4_o     = pc_plus4_q;
    assign bus.valid_o        = valid_q;
    assign bus.flush_o        = flush_q;
    assign bus.redirect_cnt_o = redirect_cnt_q;

endmodule
